// File: rtl/sd_pkg.sv
// sd_pkg: shared SD command-line encodings, frame lengths and CRC7 constants
package sd_pkg;
    typedef enum logic [1:0] {
        RESP_NONE = 2'b00,
        RESP_R1   = 2'b01,
        RESP_R3   = 2'b10,
        RESP_R2   = 2'b11
    } resp_t;
    typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECV, FINISH} state_t;
    localparam int FRAME_LEN = 48;
    localparam int LONG_LEN = 136;
    localparam logic [6:0] CRC7_POLY = 7'h09;
endpackage

// File: rtl/crc7.sv
// crc7: serial CRC7 engine, MSB-first, shared by transmit and receive paths
module crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [6:0] crc
);
    always_ff @(posedge clk)
        if (rst || clear) crc <= '0;
        else if (enable) crc <= {crc[5:0], 1'b0} ^ ((bit_in ^ crc[6]) ? CRC7_POLY : 7'd0);
endmodule

// File: rtl/cmd_driver.sv
// cmd_driver: SD CMD-line command transmitter and response receiver
module cmd_driver
    import sd_pkg::*;
#(
    parameter int RESP_TIMEOUT = 64,
    parameter int TURNAROUND = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   resp_type,
    input  logic         cmd_i,
    output logic         cmd_o,
    output logic         cmd_oe,
    output logic         busy,
    output logic         done,
    output logic [127:0] resp,
    output logic         crc_err,
    output logic         timeout
);
    localparam int CW = $clog2(RESP_TIMEOUT > LONG_LEN ? RESP_TIMEOUT : LONG_LEN) + 1;
    state_t state, state_n;
    resp_t rt;
    logic [CW-1:0] cnt, last;
    logic [39:0] tx;
    logic [126:0] sr;
    logic [127:0] sr_n;
    logic [6:0] crc;
    logic accept, tx_end, rx_start, wait_end, rx_last, crc_clr, crc_en, crc_bit;
    crc7 u_crc (.clk(clk), .rst(rst), .clear(crc_clr), .enable(crc_en), .bit_in(crc_bit), .crc(crc));
    always_comb begin
        last = rt == RESP_R2 ? CW'(LONG_LEN - 1) : CW'(FRAME_LEN - 1);
        accept = state == IDLE && start;
        tx_end = state == SEND && cnt == CW'(FRAME_LEN - 1);
        rx_start = state == WAIT_RESP && cnt > CW'(TURNAROUND) && !cmd_i;
        wait_end = state == WAIT_RESP && !rx_start && cnt == CW'(RESP_TIMEOUT - 1);
        rx_last = state == RECV && cnt == last;
        sr_n = {sr, cmd_i};
        cmd_oe = state == SEND;
        cmd_o = !cmd_oe ? 1'b1 : cnt < CW'(40) ? tx[39] : cnt == CW'(FRAME_LEN - 1) ? 1'b1 : crc[3'(CW'(FRAME_LEN - 2) - cnt)];
        busy = state != IDLE && state != FINISH;
        done = state == FINISH;
        crc_clr = accept || tx_end;
        // RX CRC covers frame bits down to 8; R2 also skips its 8-bit header
        crc_en = state == SEND ? cnt < CW'(40) : state == RECV && cnt <= last - CW'(8) && (rt != RESP_R2 || cnt >= CW'(8));
        crc_bit = state == SEND ? tx[39] : cmd_i;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = start ? SEND : IDLE;
            SEND:      state_n = !tx_end ? SEND : rt == RESP_NONE ? FINISH : WAIT_RESP;
            WAIT_RESP: state_n = rx_start ? RECV : wait_end ? FINISH : WAIT_RESP;
            RECV:      state_n = rx_last ? FINISH : RECV;
            default:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            tx <= '0;
            sr <= '0;
            rt <= RESP_NONE;
            resp <= '0;
            crc_err <= 1'b0;
            timeout <= 1'b0;
        end else begin
            cnt <= accept ? '0 : (tx_end || rx_start) ? CW'(1) : busy ? cnt + CW'(1) : '0;
            if (accept) begin
                tx <= {2'b01, cmd_index, cmd_arg};
                rt <= resp_t'(resp_type);
                crc_err <= 1'b0;
                timeout <= 1'b0;
            end else if (state == SEND) tx <= {tx[38:0], 1'b0};
            if (state == RECV) sr <= sr_n[126:0];
            if (wait_end) timeout <= 1'b1;
            if (rx_last) begin
                resp <= rt == RESP_R2 ? {sr_n[127:1], 1'b0} : {90'b0, sr_n[45:8]};
                crc_err <= !sr_n[0] || (rt != RESP_R3 && crc != sr_n[7:1]);
            end
        end
    end
endmodule

// File: tb/tb_cmd_driver.sv
// tb_cmd_driver: scoreboard bench for cmd_driver frames, responses and timing
module tb_cmd_driver;
    typedef struct packed {logic [127:0] resp; logic err; logic to;} res_t;
    logic clk = 1'b0, rst, start, cmd_i;
    logic [5:0] cmd_index;
    logic [31:0] cmd_arg;
    logic [1:0] resp_type;
    logic cmd_o, cmd_oe, busy, done, crc_err, timeout;
    logic [127:0] resp;
    int vectors = 0, miscompares = 0;
    logic [47:0] frame_q[$];
    res_t res_q[$];
    int nb = 0;
    logic [47:0] sh;
    res_t rexp;
    localparam logic [119:0] CID = 120'h035344534531364780123456780123;

    cmd_driver dut (.clk(clk), .rst(rst), .start(start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .resp_type(resp_type), .cmd_i(cmd_i), .cmd_o(cmd_o), .cmd_oe(cmd_oe), .busy(busy),
        .done(done), .resp(resp), .crc_err(crc_err), .timeout(timeout));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7m(input logic [127:0] d, input int n);
        logic [6:0] c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            logic f;
            f = d[i] ^ c[6];
            c = {c[5:0], 1'b0} ^ {3'b0, f, 2'b0, f};
        end
        return c;
    endfunction

    function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] h;
        h = {2'b01, idx, arg};
        return {h, crc7m({88'b0, h}, 40), 1'b1};
    endfunction

    always @(negedge clk) begin
        if (cmd_oe) begin
            sh = {sh[46:0], cmd_o};
            nb++;
            if (nb == 48) begin
                nb = 0;
                if (frame_q.size() == 0) check("frame_unexp", {135'b0, cmd_oe}, 136'd0);
                else check("frame", {88'b0, sh}, {88'b0, frame_q.pop_front()});
            end
        end else nb = 0;
        if (done) begin
            check("busy_at_done", {135'b0, busy}, 136'd0);
            if (res_q.size() == 0) check("done_unexp", {135'b0, done}, 136'd0);
            else begin
                rexp = res_q.pop_front();
                check("resp", {8'b0, resp}, {8'b0, rexp.resp});
                check("crc_err", {135'b0, crc_err}, {135'b0, rexp.err});
                check("timeout", {135'b0, timeout}, {135'b0, rexp.to});
            end
        end
    end

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input bit push, input logic [47:0] ef, input res_t r);
        @(negedge clk);
        cmd_index = idx;
        cmd_arg = arg;
        resp_type = rt;
        start = 1'b1;
        if (push) begin
            frame_q.push_back(ef);
            res_q.push_back(r);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drive_resp(input logic [135:0] f, input int len, input int gap);
        int n = 0;
        while (cmd_oe && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (gap) @(negedge clk);
        for (int i = len - 1; i >= 0; i--) begin
            cmd_i = f[i];
            @(negedge clk);
        end
        cmd_i = 1'b1;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        while (!done && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", {135'b0, done}, 136'd1);
    endtask

    task automatic run(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                       input logic [47:0] ef, input logic [135:0] rf, input int rlen,
                       input res_t r, input int exp_lat, input bit poke);
        int lat;
        issue(idx, arg, rt, 1'b1, ef, r);
        if (poke && rlen > 0) begin
            repeat (10) @(negedge clk);
            cmd_index = 6'h3F;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (rlen > 0) drive_resp(rf, rlen, 5);
        wait_done(400, lat);
        if (exp_lat > 0) check("latency", 136'(lat), 136'(exp_lat));
        if (poke && rlen == 0) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_pulse", {135'b0, done}, 136'd0);
        if (poke && rlen == 0) begin
            @(negedge clk);
            check("start_at_done", {135'b0, busy}, 136'd0);
        end
    endtask

    initial begin
        logic [47:0] r8, r3;
        logic [135:0] r2;
        rst = 1'b1;
        start = 1'b0;
        cmd_i = 1'b1;
        cmd_index = '0;
        cmd_arg = '0;
        resp_type = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_oe", {135'b0, cmd_oe}, 136'd0);
        check("rst_cmd_o", {135'b0, cmd_o}, 136'd1);
        check("rst_busy", {135'b0, busy}, 136'd0);
        check("rst_done", {135'b0, done}, 136'd0);
        check("rst_flags", {134'b0, crc_err, timeout}, 136'd0);
        check("rst_resp", {8'b0, resp}, 136'd0);
        run(6'd0, 32'h0, 2'b00, 48'h400000000095, '0, 0, {128'd0, 1'b0, 1'b0}, 49, 1'b1);
        run(6'd17, 32'h0, 2'b01, 48'h510000000055, '0, 0, {128'd0, 1'b0, 1'b1}, 112, 1'b0);
        r8 = 48'h08000001AA13;
        run(6'd8, 32'h1AA, 2'b01, 48'h48000001AA87, {88'b0, r8}, 48,
            {90'b0, 6'h08, 32'h000001AA, 1'b0, 1'b0}, 0, 1'b1);
        r8 = r8 ^ 48'h1000;
        run(6'd8, 32'h1AA, 2'b01, 48'h48000001AA87, {88'b0, r8}, 48,
            {90'b0, 6'h08, 32'h000001BA, 1'b1, 1'b0}, 0, 1'b0);
        r2 = {2'b00, 6'h3F, CID, crc7m({8'b0, CID}, 120), 1'b1};
        run(6'd2, 32'h0, 2'b11, cmd_frame(6'd2, 32'h0), r2, 136,
            {CID, crc7m({8'b0, CID}, 120), 1'b0, 1'b0, 1'b0}, 0, 1'b0);
        r2[0] = 1'b0;
        run(6'd2, 32'h0, 2'b11, cmd_frame(6'd2, 32'h0), r2, 136,
            {CID, crc7m({8'b0, CID}, 120), 1'b0, 1'b1, 1'b0}, 0, 1'b0);
        r3 = {2'b00, 6'h3F, 32'h80FF8000, 7'h7F, 1'b1};
        run(6'd41, 32'h40FF8000, 2'b10, cmd_frame(6'd41, 32'h40FF8000), {88'b0, r3}, 48,
            {90'b0, 6'h3F, 32'h80FF8000, 1'b0, 1'b0}, 0, 1'b0);
        r3[0] = 1'b0;
        run(6'd41, 32'h40FF8000, 2'b10, cmd_frame(6'd41, 32'h40FF8000), {88'b0, r3}, 48,
            {90'b0, 6'h3F, 32'h80FF8000, 1'b1, 1'b0}, 0, 1'b0);
        issue(6'd5, 32'hDEADBEEF, 2'b01, 1'b0, '0, '0);
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_oe", {135'b0, cmd_oe}, 136'd0);
        check("abort_busy", {135'b0, busy}, 136'd0);
        check("abort_cmd_o", {135'b0, cmd_o}, 136'd1);
        repeat (80) @(negedge clk);
        check("abort_resp", {8'b0, resp}, 136'd0);
        run(6'd0, 32'h0, 2'b00, 48'h400000000095, '0, 0, {128'd0, 1'b0, 1'b0}, 49, 1'b0);
        repeat (5) @(negedge clk);
        check("frames_left", 136'(frame_q.size()), 136'd0);
        check("results_left", 136'(res_q.size()), 136'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
